disp_share_ctrl: RTL

Scheduler that shares the 4-digit multiplexed 7-segment display between two 16-bit hex sources: a continuous source A (the reversible counter value) and an on-demand overlay source B. It generates the digit scan itself and switches source only at frame boundaries, so a frame never mixes digits from two sources. It optionally blanks leading zeros. Its outputs drive the existing hex-to-segment decoder and the AN pins.

---
 rtl/disp_pkg.sv | 36 +++
 rtl/disp_share_ctrl_if.sv | 35 +++
 rtl/scan_prescaler.sv | 52 +++++
 rtl/disp_share_ctrl.sv | 137 +++++++++++++
 4 files changed

// File: rtl/disp_pkg.sv
// -----------------------------------------------------------------------------
// disp_pkg
// Shared types and constants for the display-sharing controller.
//   disp_state_e : which source owns the current frame (SHOW_A / SHOW_B)
//   AN_ALL_OFF   : active-low digit enables with every digit dark
//   NDIGITS      : digits per frame
//   DIGIT_W      : bits per hex digit
//   msd_of()     : index of the highest nonzero nibble (0 when value is 0)
// -----------------------------------------------------------------------------
package disp_pkg;

  typedef enum logic {
    SHOW_A = 1'b0,
    SHOW_B = 1'b1
  } disp_state_e;

  localparam logic [3:0] AN_ALL_OFF = 4'b1111;
  localparam int         NDIGITS    = 4;
  localparam int         DIGIT_W    = 4;

  // Highest nonzero nibble position; an all-zero value reports digit 0 so
  // that the rightmost digit always stays lit when blanking.
  function automatic logic [1:0] msd_of(input logic [15:0] v);
    logic [1:0] m;
    m = 2'd0;
    for (int i = 0; i < NDIGITS; i++) begin
      if (v[i*DIGIT_W +: DIGIT_W] != 4'h0) begin
        m = 2'(i);
      end else begin
        m = m;
      end
    end
    return m;
  endfunction

endpackage

// File: rtl/disp_share_ctrl_if.sv
// -----------------------------------------------------------------------------
// disp_share_ctrl_if
// Bundle of source/display signals around the display-sharing controller.
//   a_data   : continuous source A value (nibble 0 = rightmost digit)
//   b_req    : level request from overlay source B
//   b_data   : overlay source B value
//   blank_lz : 1 = blank leading zero digits
//   b_ack    : one-cycle pulse when b_data is captured
//   src_b    : 1 while the current frame shows B
//   hex      : nibble for the active digit
//   an       : active-low digit enables
// master = the sources/display side, slave = the controller.
// -----------------------------------------------------------------------------
interface disp_share_ctrl_if;

  logic [15:0] a_data;
  logic        b_req;
  logic [15:0] b_data;
  logic        blank_lz;
  logic        b_ack;
  logic        src_b;
  logic [3:0]  hex;
  logic [3:0]  an;

  modport master (
    output a_data, b_req, b_data, blank_lz,
    input  b_ack, src_b, hex, an
  );

  modport slave (
    input  a_data, b_req, b_data, blank_lz,
    output b_ack, src_b, hex, an
  );

endinterface

// File: rtl/scan_prescaler.sv
// -----------------------------------------------------------------------------
// scan_prescaler
// Divides clk into digit-slot ticks and walks the digit index 0..3.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   tick : high in the last cycle of each digit slot (pcnt == SCAN_DIV-1)
//   idx  : index of the digit currently being scanned
// A frame boundary is a tick while idx == 3; the parent derives it.
// -----------------------------------------------------------------------------
module scan_prescaler #(
  parameter int SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst,
  output logic       tick,
  output logic [1:0] idx
);

  localparam int             PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]  PMAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] pcnt_q, pcnt_d;
  logic [1:0]    idx_q, idx_d;

  // Slot counter wraps on its last count and steps the digit index.
  always_comb begin
    pcnt_d = pcnt_q;
    idx_d  = idx_q;
    if (pcnt_q == PMAX) begin
      pcnt_d = '0;
      idx_d  = idx_q + 2'd1;
    end else begin
      pcnt_d = pcnt_q + PW'(1);
      idx_d  = idx_q;
    end
  end

  // Prescaler and digit index registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      idx_q  <= 2'd0;
    end else begin
      pcnt_q <= pcnt_d;
      idx_q  <= idx_d;
    end
  end

  assign tick = (pcnt_q == PMAX);
  assign idx  = idx_q;

endmodule

// File: rtl/disp_share_ctrl.sv
// -----------------------------------------------------------------------------
// disp_share_ctrl
// Shares a 4-digit multiplexed display between a continuous source A and an
// on-demand overlay source B. Source changes and data snapshots happen only
// at frame boundaries, so a frame never mixes digits of two sources.
//   clk : system clock
//   rst : synchronous active-high reset
//   bus : disp_share_ctrl_if.slave (a_data, b_req, b_data, blank_lz in;
//         b_ack, src_b, hex, an out)
// Once granted, B stays on screen for HOLD_FRAMES whole frames regardless of
// b_req; a still-high b_req at the end of the grant re-grants with fresh data.
// -----------------------------------------------------------------------------
module disp_share_ctrl
  import disp_pkg::*;
#(
  parameter int SCAN_DIV    = 100000,
  parameter int HOLD_FRAMES = 256
) (
  input  logic               clk,
  input  logic               rst,
  disp_share_ctrl_if.slave   bus
);

  localparam int            HW          = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [HW-1:0] HOLD_RELOAD = HW'(HOLD_FRAMES - 1);

  logic        tick_s;
  logic [1:0]  idx_s;
  logic        boundary_s;

  disp_state_e state_q, state_d;
  logic [HW-1:0] hold_q, hold_d;
  logic [15:0] snap_q, snap_d;
  logic        b_ack_q, b_ack_d;
  logic        src_b_q, src_b_d;

  logic [1:0]  msd_s;
  logic [3:0]  hex_s;
  logic [3:0]  an_s;

  scan_prescaler #(
    .SCAN_DIV (SCAN_DIV)
  ) u_scan (
    .clk  (clk),
    .rst  (rst),
    .tick (tick_s),
    .idx  (idx_s)
  );

  assign boundary_s = tick_s && (idx_s == 2'd3);

  // Source arbitration, snapshot load and grant hold, evaluated only at frame boundaries.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    snap_d  = snap_q;
    b_ack_d = 1'b0;
    if (boundary_s) begin
      case (state_q)
        SHOW_A: begin
          if (bus.b_req) begin
            state_d = SHOW_B;
            snap_d  = bus.b_data;
            hold_d  = HOLD_RELOAD;
            b_ack_d = 1'b1;
          end else begin
            snap_d  = bus.a_data;
          end
        end
        SHOW_B: begin
          if (hold_q != '0) begin
            // B is frozen for the whole grant; the snapshot is left alone.
            hold_d = hold_q - HW'(1);
          end else if (bus.b_req) begin
            snap_d  = bus.b_data;
            hold_d  = HOLD_RELOAD;
            b_ack_d = 1'b1;
          end else begin
            state_d = SHOW_A;
            snap_d  = bus.a_data;
          end
        end
        default: begin
          state_d = SHOW_A;
          hold_d  = '0;
          snap_d  = bus.a_data;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    src_b_d = (state_d == SHOW_B);
  end

  // Controller state, snapshot, hold counter and registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= SHOW_A;
      hold_q  <= '0;
      snap_q  <= 16'h0000;
      b_ack_q <= 1'b0;
      src_b_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      b_ack_q <= b_ack_d;
      src_b_q <= src_b_d;
    end
  end

  // Digit select and leading-zero blanking for the active scan slot.
  always_comb begin
    msd_s = msd_of(snap_q);
    case (idx_s)
      2'd0:    hex_s = snap_q[3:0];
      2'd1:    hex_s = snap_q[7:4];
      2'd2:    hex_s = snap_q[11:8];
      2'd3:    hex_s = snap_q[15:12];
      default: hex_s = 4'h0;
    endcase
    an_s = ~(4'b0001 << idx_s);
    // Digit 0 can never be above msd, so it is never blanked.
    if (bus.blank_lz && (idx_s > msd_s)) begin
      an_s  = AN_ALL_OFF;
      hex_s = 4'h0;
    end else begin
      an_s  = an_s;
    end
  end

  assign bus.hex   = hex_s;
  assign bus.an    = an_s;
  assign bus.b_ack = b_ack_q;
  assign bus.src_b = src_b_q;

endmodule
